// File: rtl/alt_mge_xcvr_atx_pll_ctrl_pkg.sv
// Shared types and constants for the MGE ATX PLL reset/lock sequencer.
package alt_mge_xcvr_atx_pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRDN     = 3'd0,
    WAIT_CAL  = 3'd1,
    WAIT_LOCK = 3'd2,
    MCGB      = 3'd3,
    READY     = 3'd4,
    FAIL      = 3'd5
  } pll_state_e;

  localparam int RETRY_W = 4;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/alt_mge_xcvr_atx_pll_seq.sv
// One ATX PLL: input synchronisers, power-down/calibrate/lock/MCGB sequencing FSM,
// saturating counters and registered control outputs.
module alt_mge_xcvr_atx_pll_seq
  import alt_mge_xcvr_atx_pll_ctrl_pkg::*;
#(
  parameter int PWRDN_CYCLES   = 1000,
  parameter int FILTER_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MCGB_CYCLES    = 32,
  parameter int MAX_RETRY      = 3,
  parameter int AUTO_RELOCK    = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               relock_req_i,
  input  logic               pll_locked_i,
  input  logic               pll_cal_busy_i,
  output logic               pll_powerdown_o,
  output logic               mcgb_rst_o,
  output logic               pll_ready_o,
  output logic               lock_lost_o,
  output logic               pll_fail_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int CNT_W = $clog2(max_of4(PWRDN_CYCLES, FILTER_CYCLES, TIMEOUT_CYCLES, MCGB_CYCLES)) + 1;
  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   PWRDN_LAST = CNT_W'(PWRDN_CYCLES - 1);
  localparam logic [CNT_W-1:0]   MCGB_LAST  = CNT_W'(MCGB_CYCLES - 1);
  localparam logic [CNT_W-1:0]   FILT_LIM   = CNT_W'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0]   TMO_LIM    = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_ZERO = {RETRY_W{1'b0}};
  localparam logic [RETRY_W-1:0] RETRY_LIM  = RETRY_W'(MAX_RETRY);

  logic               lock_meta_q, lock_sync_q, cal_meta_q, cal_sync_q;
  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, filt_q, filt_d, tmo_q, tmo_d;
  logic [CNT_W-1:0]   cnt_inc, filt_inc, tmo_inc;
  logic [RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic               lost_q, lost_d;
  logic               pwrdn_q, mcgb_q, ready_q, fail_q;

  assign cnt_inc   = (&cnt_q)   ? cnt_q   : cnt_q   + CNT_ONE;
  assign filt_inc  = (&filt_q)  ? filt_q  : filt_q  + CNT_ONE;
  assign tmo_inc   = (&tmo_q)   ? tmo_q   : tmo_q   + CNT_ONE;
  assign retry_inc = (&retry_q) ? retry_q : retry_q + 4'd1;

  // Busy resets high so a PLL is never treated as calibrated straight out of reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      cal_meta_q  <= 1'b1;
      cal_sync_q  <= 1'b1;
    end else begin
      lock_meta_q <= pll_locked_i;
      lock_sync_q <= lock_meta_q;
      cal_meta_q  <= pll_cal_busy_i;
      cal_sync_q  <= cal_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    tmo_d   = tmo_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    if (relock_req_i) begin
      state_d = PWRDN;
      cnt_d   = CNT_ZERO;
      filt_d  = CNT_ZERO;
      tmo_d   = CNT_ZERO;
      retry_d = RETRY_ZERO;
      lost_d  = 1'b0;
    end else if (!en_i) begin
      state_d = PWRDN;
      cnt_d   = CNT_ZERO;
      filt_d  = CNT_ZERO;
      tmo_d   = CNT_ZERO;
    end else begin
      case (state_q)
        PWRDN: begin
          if (cnt_q >= PWRDN_LAST) begin
            state_d = WAIT_CAL;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WAIT_CAL: begin
          if (!cal_sync_q) begin
            state_d = WAIT_LOCK;
            filt_d  = CNT_ZERO;
            tmo_d   = CNT_ZERO;
          end else begin
            state_d = WAIT_CAL;
          end
        end
        WAIT_LOCK: begin
          filt_d = lock_sync_q ? filt_inc : CNT_ZERO;
          tmo_d  = tmo_inc;
          // A lock that qualifies on the same cycle as the timeout is honoured.
          if (lock_sync_q && (filt_inc >= FILT_LIM)) begin
            state_d = MCGB;
            cnt_d   = CNT_ZERO;
          end else if (tmo_inc >= TMO_LIM) begin
            retry_d = retry_inc;
            cnt_d   = CNT_ZERO;
            state_d = (retry_inc > RETRY_LIM) ? FAIL : PWRDN;
          end else begin
            state_d = WAIT_LOCK;
          end
        end
        MCGB: begin
          if (!lock_sync_q) begin
            state_d = WAIT_LOCK;
            filt_d  = CNT_ZERO;
            tmo_d   = CNT_ZERO;
          end else if (cnt_q >= MCGB_LAST) begin
            state_d = READY;
            cnt_d   = CNT_ZERO;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        READY: begin
          if (!lock_sync_q || cal_sync_q) begin
            lost_d = 1'b1;
            if (AUTO_RELOCK != 0) begin
              state_d = PWRDN;
              cnt_d   = CNT_ZERO;
            end else begin
              state_d = WAIT_LOCK;
              filt_d  = CNT_ZERO;
              tmo_d   = CNT_ZERO;
            end
          end else begin
            state_d = READY;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = PWRDN;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the registered state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= PWRDN;
      cnt_q   <= CNT_ZERO;
      filt_q  <= CNT_ZERO;
      tmo_q   <= CNT_ZERO;
      retry_q <= RETRY_ZERO;
      lost_q  <= 1'b0;
      pwrdn_q <= 1'b1;
      mcgb_q  <= 1'b1;
      ready_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      filt_q  <= filt_d;
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      pwrdn_q <= (state_d == PWRDN) || (state_d == FAIL);
      mcgb_q  <= (state_d != READY);
      ready_q <= (state_d == READY);
      fail_q  <= (state_d == FAIL);
    end
  end

  assign pll_powerdown_o = pwrdn_q;
  assign mcgb_rst_o      = mcgb_q;
  assign pll_ready_o     = ready_q;
  assign lock_lost_o     = lost_q;
  assign pll_fail_o      = fail_q;
  assign retry_cnt_o     = retry_q;

endmodule

// File: rtl/alt_mge_xcvr_atx_pll_ctrl.sv
// Top: NUM_PLL independent ATX PLL sequencers plus the aggregate ready toward TX reset release.
module alt_mge_xcvr_atx_pll_ctrl
  import alt_mge_xcvr_atx_pll_ctrl_pkg::*;
#(
  parameter int NUM_PLL        = 2,
  parameter int PWRDN_CYCLES   = 1000,
  parameter int FILTER_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MCGB_CYCLES    = 32,
  parameter int MAX_RETRY      = 3,
  parameter int AUTO_RELOCK    = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic [NUM_PLL-1:0]         en_i,
  input  logic [NUM_PLL-1:0]         relock_req_i,
  input  logic [NUM_PLL-1:0]         pll_locked_i,
  input  logic [NUM_PLL-1:0]         pll_cal_busy_i,
  output logic [NUM_PLL-1:0]         pll_powerdown_o,
  output logic [NUM_PLL-1:0]         mcgb_rst_o,
  output logic [NUM_PLL-1:0]         pll_ready_o,
  output logic                       all_ready_o,
  output logic [NUM_PLL-1:0]         lock_lost_o,
  output logic [NUM_PLL-1:0]         pll_fail_o,
  output logic [RETRY_W*NUM_PLL-1:0] retry_cnt_o
);

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_pll
    alt_mge_xcvr_atx_pll_seq #(
      .PWRDN_CYCLES  (PWRDN_CYCLES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .MCGB_CYCLES   (MCGB_CYCLES),
      .MAX_RETRY     (MAX_RETRY),
      .AUTO_RELOCK   (AUTO_RELOCK)
    ) u_seq (
      .clk_i          (clk_i),
      .reset_n_i      (reset_n_i),
      .en_i           (en_i[g]),
      .relock_req_i   (relock_req_i[g]),
      .pll_locked_i   (pll_locked_i[g]),
      .pll_cal_busy_i (pll_cal_busy_i[g]),
      .pll_powerdown_o(pll_powerdown_o[g]),
      .mcgb_rst_o     (mcgb_rst_o[g]),
      .pll_ready_o    (pll_ready_o[g]),
      .lock_lost_o    (lock_lost_o[g]),
      .pll_fail_o     (pll_fail_o[g]),
      .retry_cnt_o    (retry_cnt_o[g*RETRY_W +: RETRY_W])
    );
  end

  // Disabled PLLs are masked out; with nothing enabled the link is never ready.
  assign all_ready_o = (|en_i) & (&(pll_ready_o | ~en_i));

endmodule

// File: tb/tb_alt_mge_xcvr_atx_pll_ctrl.sv
// Directed scenarios plus randomised traffic, checked every cycle against a behavioural model.
module tb_alt_mge_xcvr_atx_pll_ctrl;

  localparam int NP = 2;
  localparam int PW = 8;
  localparam int FI = 4;
  localparam int TO = 64;
  localparam int MC = 4;
  localparam int MR = 2;

  localparam int P_OFF  = 0;
  localparam int P_CAL  = 1;
  localparam int P_LOCK = 2;
  localparam int P_MCGB = 3;
  localparam int P_UP   = 4;
  localparam int P_DEAD = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NP-1:0] en, relock, locked, cal_busy;
  logic [NP-1:0] pll_powerdown, mcgb_rst, pll_ready, lock_lost, pll_fail;
  logic          all_ready;
  logic [7:0]    retry_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  int ph[NP], rem[NP], streak[NP], waited[NP], retries[NP];
  bit lost[NP];
  bit lsync[NP][2], csync[NP][2];

  always #5 clk = ~clk;

  alt_mge_xcvr_atx_pll_ctrl #(
    .NUM_PLL(NP), .PWRDN_CYCLES(PW), .FILTER_CYCLES(FI), .TIMEOUT_CYCLES(TO),
    .MCGB_CYCLES(MC), .MAX_RETRY(MR), .AUTO_RELOCK(1)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .relock_req_i(relock),
    .pll_locked_i(locked), .pll_cal_busy_i(cal_busy),
    .pll_powerdown_o(pll_powerdown), .mcgb_rst_o(mcgb_rst), .pll_ready_o(pll_ready),
    .all_ready_o(all_ready), .lock_lost_o(lock_lost), .pll_fail_o(pll_fail),
    .retry_cnt_o(retry_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bound_chk(input string tag, input bit reached);
    n_cmp++;
    assert (reached) else begin
      n_bad++;
      $error("FAIL %s: wait bound expired, observed 0 expected 1", tag);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      ph[i] = P_OFF; rem[i] = PW; streak[i] = 0; waited[i] = 0; retries[i] = 0; lost[i] = 1'b0;
      lsync[i][0] = 1'b0; lsync[i][1] = 1'b0;
      csync[i][0] = 1'b1; csync[i][1] = 1'b1;
    end
  endtask

  task automatic enter_lock(input int i);
    ph[i] = P_LOCK; streak[i] = 0; waited[i] = 0;
  endtask

  task automatic model_edge();
    for (int i = 0; i < NP; i++) begin
      bit lk, cb;
      lk = lsync[i][1]; cb = csync[i][1];
      lsync[i][1] = lsync[i][0]; lsync[i][0] = locked[i];
      csync[i][1] = csync[i][0]; csync[i][0] = cal_busy[i];
      if (relock[i]) begin
        ph[i] = P_OFF; rem[i] = PW; retries[i] = 0; lost[i] = 1'b0;
      end else if (!en[i]) begin
        ph[i] = P_OFF; rem[i] = PW;
      end else begin
        case (ph[i])
          P_OFF: begin
            rem[i]--;
            if (rem[i] == 0) ph[i] = P_CAL;
          end
          P_CAL: if (!cb) enter_lock(i);
          P_LOCK: begin
            waited[i]++;
            streak[i] = lk ? streak[i] + 1 : 0;
            if (streak[i] == FI) begin
              ph[i] = P_MCGB; rem[i] = MC;
            end else if (waited[i] == TO) begin
              if (retries[i] < 15) retries[i]++;
              if (retries[i] > MR) ph[i] = P_DEAD;
              else begin ph[i] = P_OFF; rem[i] = PW; end
            end
          end
          P_MCGB: begin
            if (!lk) enter_lock(i);
            else begin
              rem[i]--;
              if (rem[i] == 0) ph[i] = P_UP;
            end
          end
          P_UP: if (!lk || cb) begin lost[i] = 1'b1; ph[i] = P_OFF; rem[i] = PW; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic check_all();
    logic [NP-1:0] e_pd, e_mc, e_rd, e_fl, e_ll;
    logic [7:0]    e_rt;
    logic          e_all;
    for (int i = 0; i < NP; i++) begin
      e_pd[i] = (ph[i] == P_OFF) || (ph[i] == P_DEAD);
      e_mc[i] = (ph[i] != P_UP);
      e_rd[i] = (ph[i] == P_UP);
      e_fl[i] = (ph[i] == P_DEAD);
      e_ll[i] = lost[i];
      e_rt[i*4 +: 4] = 4'(retries[i]);
    end
    e_all = (en != 2'b00) && ((e_rd | ~en) == 2'b11);
    chk("powerdown", {6'd0, pll_powerdown}, {6'd0, e_pd});
    chk("mcgb_rst",  {6'd0, mcgb_rst},      {6'd0, e_mc});
    chk("pll_ready", {6'd0, pll_ready},     {6'd0, e_rd});
    chk("all_ready", {7'd0, all_ready},     {7'd0, e_all});
    chk("lock_lost", {6'd0, lock_lost},     {6'd0, e_ll});
    chk("pll_fail",  {6'd0, pll_fail},      {6'd0, e_fl});
    chk("retry_cnt", retry_cnt,             e_rt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic cycn(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pd"},    {6'd0, pll_powerdown}, 8'h03);
    chk({tag, "_mcgb"},  {6'd0, mcgb_rst},      8'h03);
    chk({tag, "_ready"}, {6'd0, pll_ready},     8'h00);
    chk({tag, "_all"},   {7'd0, all_ready},     8'h00);
    chk({tag, "_lost"},  {6'd0, lock_lost},     8'h00);
    chk({tag, "_fail"},  {6'd0, pll_fail},      8'h00);
    chk({tag, "_retry"}, retry_cnt,             8'h00);
  endtask

  initial begin
    int k;
    int pdc;
    reset_n = 1'b0; en = 2'b00; relock = 2'b00; locked = 2'b00; cal_busy = 2'b11;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    reset_n = 1'b1;
    en = 2'b11;

    // Bring-up: calibration ends at cycle 10, lock from cycle 12.
    for (int c = 0; c < 30; c++) begin
      if (c == 10) cal_busy = 2'b00;
      if (c == 12) locked = 2'b11;
      cyc();
    end
    chk("s1_ready", {6'd0, pll_ready}, 8'h03);
    chk("s1_all", {7'd0, all_ready}, 8'h01);

    // One-cycle lock glitch at filter count 3 restarts qualification.
    relock = 2'b11; cyc(); relock = 2'b00;
    k = 0;
    while (!(ph[0] == P_LOCK && streak[0] == 1) && k < 40) begin cyc(); k++; end
    bound_chk("s2_reach", k < 40);
    locked[0] = 1'b0; cyc(); locked[0] = 1'b1;
    cycn(8);
    chk("s2_glitch_hold", {7'd0, pll_ready[0]}, 8'h00);
    cycn(5);
    chk("s2_ready", {7'd0, pll_ready[0]}, 8'h01);

    // No lock ever: retries exhaust into the fail state.
    locked = 2'b00;
    relock = 2'b11; cyc(); relock = 2'b00;
    k = 0;
    while (!(ph[0] == P_DEAD && ph[1] == P_DEAD) && k < 400) begin cyc(); k++; end
    bound_chk("s3_reach", k < 400);
    chk("s3_fail", {6'd0, pll_fail}, 8'h03);
    chk("s3_retry", retry_cnt, 8'h33);
    chk("s3_pd", {6'd0, pll_powerdown}, 8'h03);
    relock = 2'b11; cyc(); relock = 2'b00;
    chk("s3_clr_fail", {6'd0, pll_fail}, 8'h00);
    chk("s3_clr_retry", retry_cnt, 8'h00);
    chk("s3_clr_pd", {6'd0, pll_powerdown}, 8'h03);

    // Lock loss in READY triggers a full power-down.
    locked = 2'b11;
    k = 0;
    while (!(ph[0] == P_UP && ph[1] == P_UP) && k < 60) begin cyc(); k++; end
    bound_chk("s4_reach", k < 60);
    locked[0] = 1'b0;
    k = 0;
    while (!lost[0] && k < 10) begin cyc(); k++; end
    bound_chk("s4_loss", k < 10);
    chk("s4_lost", {7'd0, lock_lost[0]}, 8'h01);
    chk("s4_ready", {7'd0, pll_ready[0]}, 8'h00);
    pdc = int'(pll_powerdown[0]);
    locked[0] = 1'b1;
    for (int j = 0; j < 11; j++) begin cyc(); pdc += int'(pll_powerdown[0]); end
    chk("s4_pd_len", 8'(pdc), 8'd8);

    // Partial enable, then nothing enabled.
    en = 2'b01;
    cycn(40);
    chk("s5_pd1", {7'd0, pll_powerdown[1]}, 8'h01);
    chk("s5_rdy1", {7'd0, pll_ready[1]}, 8'h00);
    chk("s5_all", {7'd0, all_ready}, 8'h01);
    en = 2'b00;
    cyc();
    chk("s5_all_off", {7'd0, all_ready}, 8'h00);

    // Asynchronous reset in the middle of the MCGB phase.
    en = 2'b11;
    k = 0;
    while (ph[0] != P_MCGB && k < 60) begin cyc(); k++; end
    bound_chk("s6_reach", k < 60);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("s6");
    @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // Randomised traffic; long unlocked stretches let timeouts and failures occur.
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < NP; i++) begin
        if (locked[i]) begin
          if ($urandom_range(29) == 0) locked[i] = 1'b0;
        end else begin
          if ($urandom_range(79) == 0) locked[i] = 1'b1;
        end
        if ($urandom_range(59) == 0) cal_busy[i] = ~cal_busy[i];
        relock[i] = ($urandom_range(199) == 0);
        if ($urandom_range(299) == 0) en[i] = ~en[i];
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
